vga_timing_gen: RTL and testbench

- Pixel/line timing generator for the 800x600@60 Hz display path; counterpart of the game logic block on the pixel interface.
- Drives PixelX/PixelY and a per-frame move strobe into the game logic, and receives that block's registered R/G/B back.
- Produces VGA hsync/vsync and outputs blanking-gated colour, pipeline-aligned to the sync signals for the DAC/connector pins.

---
 rtl/vga_timing_gen.sv | 134 +++++++++++++
 tb/tb_vga_timing_gen.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Pixel/line timing generator for the 800x600@60 display path.
// Emits counters and a mover strobe to the game logic and returns aligned sync and RGB.
module vga_timing_gen #(
    parameter int H_VISIBLE       = 800,
    parameter int H_FRONT         = 40,
    parameter int H_SYNC          = 128,
    parameter int H_BACK          = 88,
    parameter int V_VISIBLE       = 600,
    parameter int V_FRONT         = 1,
    parameter int V_SYNC          = 4,
    parameter int V_BACK          = 23,
    parameter bit H_POL           = 1'b1,
    parameter bit V_POL           = 1'b1,
    parameter int PIPE_DELAY      = 1,
    parameter int FRAMES_PER_MOVE = 4
) (
    input  logic        uclk,
    input  logic        reset,
    input  logic        pix_ce,
    input  logic [2:0]  R_in,
    input  logic [2:0]  G_in,
    input  logic [1:0]  B_in,
    output logic [10:0] PixelX,
    output logic [10:0] PixelY,
    output logic        mover,
    output logic        frame_tick,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic [2:0]  R,
    output logic [2:0]  G,
    output logic [1:0]  B
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam logic [10:0] H_ACT    = 11'(H_VISIBLE);
    localparam logic [10:0] V_ACT    = 11'(V_VISIBLE);
    localparam logic [7:0]  FPM_LAST = 8'(FRAMES_PER_MOVE - 1);

    logic                  hs_raw;
    logic                  vs_raw;
    logic                  act_raw;
    logic                  frame_end;
    logic [PIPE_DELAY-1:0] hs_pipe;
    logic [PIPE_DELAY-1:0] vs_pipe;
    logic [PIPE_DELAY-1:0] act_pipe;
    logic [7:0]            frame_cnt;

    always_comb begin
        hs_raw    = (PixelX >= HS_START) && (PixelX <= HS_END);
        vs_raw    = (PixelY >= VS_START) && (PixelY <= VS_END);
        act_raw   = (PixelX < H_ACT) && (PixelY < V_ACT);
        frame_end = pix_ce && (PixelX == H_LAST) && (PixelY == V_LAST);
    end

    always_ff @(posedge uclk) begin
        if (reset) begin
            PixelX <= '0;
            PixelY <= '0;
        end else if (pix_ce) begin
            if (PixelX == H_LAST) begin
                PixelX <= '0;
                PixelY <= (PixelY == V_LAST) ? 11'd0 : PixelY + 11'd1;
            end else begin
                PixelX <= PixelX + 11'd1;
            end
        end
    end

    // Delay line absorbs the game logic's RGB register latency.
    always_ff @(posedge uclk) begin
        if (reset) begin
            hs_pipe  <= '0;
            vs_pipe  <= '0;
            act_pipe <= '0;
        end else if (pix_ce) begin
            hs_pipe[0]  <= hs_raw;
            vs_pipe[0]  <= vs_raw;
            act_pipe[0] <= act_raw;
            for (int i = 1; i < PIPE_DELAY; i++) begin
                hs_pipe[i]  <= hs_pipe[i-1];
                vs_pipe[i]  <= vs_pipe[i-1];
                act_pipe[i] <= act_pipe[i-1];
            end
        end
    end

    always_ff @(posedge uclk) begin
        if (reset) begin
            hsync    <= !H_POL;
            vsync    <= !V_POL;
            video_on <= 1'b0;
            R        <= '0;
            G        <= '0;
            B        <= '0;
        end else if (pix_ce) begin
            hsync    <= H_POL ? hs_pipe[PIPE_DELAY-1] : !hs_pipe[PIPE_DELAY-1];
            vsync    <= V_POL ? vs_pipe[PIPE_DELAY-1] : !vs_pipe[PIPE_DELAY-1];
            video_on <= act_pipe[PIPE_DELAY-1];
            R        <= act_pipe[PIPE_DELAY-1] ? R_in : 3'd0;
            G        <= act_pipe[PIPE_DELAY-1] ? G_in : 3'd0;
            B        <= act_pipe[PIPE_DELAY-1] ? B_in : 2'd0;
        end
    end

    // mover changes only at frame boundaries so the game logic sees whole frames.
    always_ff @(posedge uclk) begin
        if (reset) begin
            frame_cnt  <= '0;
            mover      <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= frame_end;
            if (frame_end) begin
                if (frame_cnt == FPM_LAST) begin
                    frame_cnt <= '0;
                    mover     <= 1'b1;
                end else begin
                    frame_cnt <= frame_cnt + 8'd1;
                    mover     <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a reduced geometry; a step-indexed model
// feeds a scoreboard queue, plus explicit sync/mover/reset checks.
module tb_vga_timing_gen;

    localparam int HV = 8, HF = 2, HS = 3, HB = 3;
    localparam int VV = 6, VF = 1, VS = 2, VB = 1;
    localparam bit HP = 1'b1, VP = 1'b1;
    localparam int FPM = 4;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FT = HT * VT;

    logic        uclk = 1'b0;
    logic        reset = 1'b1;
    logic        pix_ce = 1'b0;
    logic [2:0]  R_in = '0;
    logic [2:0]  G_in = '0;
    logic [1:0]  B_in = '0;
    logic [10:0] PixelX, PixelY;
    logic        mover, frame_tick, hsync, vsync, video_on;
    logic [2:0]  R, G;
    logic [1:0]  B;

    always #5 uclk = ~uclk;

    vga_timing_gen #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .H_POL(HP), .V_POL(VP), .PIPE_DELAY(1), .FRAMES_PER_MOVE(FPM)
    ) dut (
        .uclk(uclk), .reset(reset), .pix_ce(pix_ce),
        .R_in(R_in), .G_in(G_in), .B_in(B_in),
        .PixelX(PixelX), .PixelY(PixelY), .mover(mover),
        .frame_tick(frame_tick), .hsync(hsync), .vsync(vsync),
        .video_on(video_on), .R(R), .G(G), .B(B)
    );

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic        ft;
        logic        mv;
        logic        hs;
        logic        vs;
        logic        von;
        logic [2:0]  r;
        logic [2:0]  g;
        logic [1:0]  b;
    } obs_t;

    typedef struct {
        bit          toggle;
        int          cycles;
        logic [2:0]  r;
        logic [2:0]  g;
        logic [1:0]  b;
    } phase_t;

    obs_t sbq[$];
    obs_t exp_last;
    int   n_model = 0;
    int   errors = 0;
    int   checks = 0;
    int   hs_hi, ft_cnt, mv_rise, pc, hs_rise_at, hs_fall_at;
    logic mv_prev, hs_prev;

    function automatic obs_t model(int n, logic [2:0] r, logic [2:0] g,
                                   logic [1:0] b);
        obs_t e;
        int   m, xm, ym, f;
        logic h, v, a;
        e = '0;
        e.x = 11'(n % HT);
        e.y = 11'((n / HT) % VT);
        f = n / FT;
        e.mv = (f > 0) && (f % FPM == 0);
        h = 1'b0; v = 1'b0; a = 1'b0;
        if (n >= 2) begin
            m = n - 2;
            xm = m % HT;
            ym = (m / HT) % VT;
            h = (xm >= HV + HF) && (xm < HV + HF + HS);
            v = (ym >= VV + VF) && (ym < VV + VF + VS);
            a = (xm < HV) && (ym < VV);
        end
        e.hs = HP ? h : !h;
        e.vs = VP ? v : !v;
        e.von = a;
        if (a) begin
            e.r = r; e.g = g; e.b = b;
        end
        return e;
    endfunction

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step(bit ce, bit rst, logic [2:0] r, logic [2:0] g,
                        logic [1:0] b);
        obs_t got, e;
        @(negedge uclk);
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            got = '{PixelX, PixelY, frame_tick, mover, hsync, vsync,
                    video_on, R, G, B};
            checks++;
            if (got !== e) begin
                errors++;
                if (errors <= 20)
                    $display("FAIL scoreboard t=%0t got=%h expected=%h (x=%0d y=%0d vs x=%0d y=%0d)",
                             $time, got, e, got.x, got.y, e.x, e.y);
            end
            hs_hi += int'(got.hs);
            ft_cnt += int'(got.ft);
            if (got.mv && !mv_prev) mv_rise++;
            if (got.hs && !hs_prev && hs_rise_at < 0) hs_rise_at = pc;
            if (!got.hs && hs_prev && hs_fall_at < 0) hs_fall_at = pc;
            mv_prev = got.mv;
            hs_prev = got.hs;
            pc++;
        end
        reset = rst;
        pix_ce = ce;
        R_in = r; G_in = g; B_in = b;
        if (rst) begin
            n_model = 0;
            e = model(0, r, g, b);
        end else if (ce) begin
            n_model++;
            e = model(n_model, r, g, b);
            e.ft = (n_model % FT == 0);
        end else begin
            e = exp_last;
            e.ft = 1'b0;
        end
        exp_last = e;
        sbq.push_back(e);
    endtask

    phase_t ph[3];
    int guard;

    initial begin
        ph[0] = '{1'b0, HT, 3'b101, 3'b000, 2'b00};
        ph[1] = '{1'b0, 9 * FT + 5 - HT, 3'b011, 3'b110, 2'b10};
        ph[2] = '{1'b1, 2 * FT + 7, 3'b110, 3'b001, 2'b01};
        mv_prev = 1'b0; hs_prev = 1'b0;
        hs_hi = 0; ft_cnt = 0; mv_rise = 0; pc = 0;
        hs_rise_at = -1; hs_fall_at = -1;

        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 3'd0, 3'd0, 2'd0);
        hs_hi = 0; ft_cnt = 0; mv_rise = 0; pc = 0;
        hs_rise_at = -1; hs_fall_at = -1;

        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < ph[p].cycles; c++) begin
                if (ph[p].toggle && c[0])
                    step(1'b0, 1'b0, 3'($urandom), 3'($urandom), 2'($urandom));
                else
                    step(1'b1, 1'b0, ph[p].r, ph[p].g, ph[p].b);
            end
            if (p == 0) begin
                chk("hsync_high_steps_line0", hs_hi, HS);
                chk("hsync_rise_step", hs_rise_at, HV + HF + 2);
                chk("hsync_fall_step", hs_fall_at, HV + HF + HS + 2);
            end
            if (p == 1) begin
                chk("frame_ticks_9_frames", ft_cnt, 9);
                chk("mover_rises_9_frames", mv_rise, 2);
            end
        end

        guard = 0;
        while (!(exp_last.x == 11'd5 && exp_last.y == 11'd4 && exp_last.mv)
               && guard < 4000) begin
            step(guard[0] ? 1'b0 : 1'b1, 1'b0, 3'b111, 3'b111, 2'b11);
            guard++;
        end
        chk("reach_midframe_within_budget", int'(guard < 4000), 1);
        step(1'b0, 1'b0, 3'b111, 3'b111, 2'b11);
        chk("mover_before_reset", int'(mover), 1);
        chk("x_before_reset", int'(PixelX), 5);
        step(1'b1, 1'b1, 3'b111, 3'b111, 2'b11);
        step(1'b0, 1'b0, 3'b111, 3'b111, 2'b11);
        chk("reset_x", int'(PixelX), 0);
        chk("reset_y", int'(PixelY), 0);
        chk("reset_mover", int'(mover), 0);
        chk("reset_rgb", int'({R, G, B}), 0);
        chk("reset_hsync", int'(hsync), int'(!HP));

        for (int c = 0; c < 2 * FT; c++)
            step(c[0] ? 1'b0 : 1'b1, 1'b0, 3'b010, 3'b101, 2'b11);
        for (int c = 0; c < 50; c++)
            step(1'b1, 1'b0, 3'b001, 3'b010, 2'b01);
        step(1'b0, 1'b0, 3'd0, 3'd0, 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
